// File: rtl/tagged_dispatch_fifo.sv
// tagged_dispatch_fifo: single in-order ingress FIFO of {tag,data} entries dispatched
// to one of NUM_CHANNELS consumers, gated by per-channel credit counters.
// Head-of-line blocking is intentional: a head with no credit stalls every channel.
// Optional feature macro: DISPATCH_BYPASS_EN (an empty FIFO forwards a creditable push
// straight to the output registers, giving one cycle of latency instead of two).
module tagged_dispatch_fifo #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CREDITS      = 2,
  parameter int unsigned TAGWIDTH     = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [TAGWIDTH-1:0]          push_tag,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [NUM_CHANNELS-1:0]      credit_ret,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [NUM_CHANNELS-1:0]      out_vld,
  output logic [TAGWIDTH-1:0]          out_tag,
  output logic [WIDTH-1:0]             data_out,
  output logic                         err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = $clog2(CREDITS + 1);

  typedef struct packed {
    logic [TAGWIDTH-1:0] tag;
    logic [WIDTH-1:0]    data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr_next;
  logic [PW-1:0]         wr_ptr_next;
  logic [CW-1:0]         count_next;
  logic [KW-1:0]         credit      [NUM_CHANNELS];
  logic [KW-1:0]         credit_next [NUM_CHANNELS];

  entry_t                head;
  logic                  tag_ok;
  logic                  pop;
  logic                  bypass;
  logic                  disp;
  logic                  accept;
  logic                  push_err;
  logic                  ovf;
  logic [TAGWIDTH-1:0]   disp_tag;
  logic [WIDTH-1:0]      disp_data;
  logic [NUM_CHANNELS-1:0] vld_c;

  assign head   = mem[rd_ptr];
  assign tag_ok = 32'(push_tag) < NUM_CHANNELS;
  assign pop    = !empty && (credit[head.tag] != '0);

`ifdef DISPATCH_BYPASS_EN
  assign bypass = empty && push && tag_ok && (credit[push_tag] != '0);
`else
  assign bypass = 1'b0;
`endif

  assign disp      = pop || bypass;
  assign disp_tag  = pop ? head.tag  : push_tag;
  assign disp_data = pop ? head.data : data_in;

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign accept   = push && tag_ok && !bypass && (!full || pop);
  assign push_err = push && (!tag_ok || (full && !pop));

  // One-hot dispatch strobe for the channel being served this cycle
  always_comb begin
    vld_c = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      vld_c[k] = disp && (disp_tag == TAGWIDTH'(k));
    end
  end

  // Pointer and occupancy next-state; pointers wrap explicitly so DEPTH may be non-power-of-2
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    if (pop) begin
      rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
    if (accept) begin
      wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    end
    count_next = count + CW'(accept) - CW'(pop);
  end

  // Credit next-state: return and dispatch on the same channel cancel; return at max overflows
  always_comb begin
    ovf = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      credit_next[k] = credit[k];
      if (credit_ret[k] && !vld_c[k]) begin
        if (credit[k] == KW'(CREDITS)) begin
          ovf = 1'b1;
        end else begin
          credit_next[k] = credit[k] + KW'(1);
        end
      end else if (!credit_ret[k] && vld_c[k]) begin
        credit_next[k] = credit[k] - KW'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written so no reset is needed
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= entry_t'{tag: push_tag, data: data_in};
    end
  end

  // FIFO control, credits and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      err    <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        credit[k] <= KW'(CREDITS);
      end
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
      full   <= (count_next == CW'(DEPTH));
      empty  <= (count_next == '0);
      err    <= err | push_err | ovf;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        credit[k] <= credit_next[k];
      end
    end
  end

  // Registered dispatch outputs; tag and payload hold between dispatches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= '0;
      out_tag  <= '0;
      data_out <= '0;
    end else begin
      out_vld <= vld_c;
      if (disp) begin
        out_tag  <= disp_tag;
        data_out <= disp_data;
      end
    end
  end

endmodule
